// File: rtl/mips_revc_pkg.sv
// Shared encodings, FSM/ALU enums and decode helpers for the revC multicycle core.
package mips_revc_pkg;

  localparam int INSTR_W = 32;
  localparam int REG_CNT = 32;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_HALT
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT
  } alu_op_t;

  function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_RTYPE: ok = (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) ||
                     (fn == FN_OR)  || (fn == FN_SLT);
      OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW, OP_HALT: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Non-R-type users of the ALU (ADDI, address generation) always add.
  function automatic alu_op_t alu_sel(input logic [5:0] op, input logic [5:0] fn);
    alu_op_t sel;
    sel = ALU_ADD;
    if (op == OP_RTYPE) begin
      case (fn)
        FN_SUB:  sel = ALU_SUB;
        FN_AND:  sel = ALU_AND;
        FN_OR:   sel = ALU_OR;
        FN_SLT:  sel = ALU_SLT;
        default: sel = ALU_ADD;
      endcase
    end
    return sel;
  endfunction

endpackage

// File: rtl/mips_regfile_revc.sv
// 32x32 register file, two asynchronous read ports, one synchronous write port.
// Latency: reads combinational, write lands on the next rising edge.
// Backpressure: none; $0 reads zero and ignores writes.
module mips_regfile_revc
  import mips_revc_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [4:0]         ra1,
  input  logic [4:0]         ra2,
  output logic [INSTR_W-1:0] rd1,
  output logic [INSTR_W-1:0] rd2,
  input  logic               we,
  input  logic [4:0]         wa,
  input  logic [INSTR_W-1:0] wd
);

  logic [INSTR_W-1:0] regs [REG_CNT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_CNT; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (wa != 5'd0)) begin
      regs[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == 5'd0) ? '0 : regs[ra1];
  assign rd2 = (ra2 == 5'd0) ? '0 : regs[ra2];

endmodule

// File: rtl/mips_cpu_revc.sv
// Multicycle MIPS-subset core on a shared req/ack memory port, with HALT, trap and retire.
// Latency: BEQ/J 3, R-type/ADDI/SW 4, LW 5 cycles with zero-wait memory; +1 per wait cycle.
// Backpressure: req/we/addr/wdata held stable until ack; ack while req is low is ignored.
module mips_cpu_revc
  import mips_revc_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic              halted,
  output logic              trap,
  output logic              retire,
  output logic [ADDR_W-1:0] pc_dbg
);

  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

  state_t             state;
  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  br_target;
  logic [INSTR_W-1:0] ir;
  logic [INSTR_W-1:0] a_reg;
  logic [INSTR_W-1:0] b_reg;
  logic [INSTR_W-1:0] alu_out;
  logic [INSTR_W-1:0] mdr;

  logic [5:0]         opcode;
  logic [5:0]         funct;
  logic [4:0]         rs;
  logic [4:0]         rt;
  logic [4:0]         rd;
  logic [31:0]        simm;
  logic [31:0]        alu_b;
  logic [31:0]        alu_res;
  logic [31:0]        addr_sum;
  logic [31:0]        j_full;
  logic [ADDR_W-1:0]  pc_plus4;
  logic [ADDR_W-1:0]  br_calc;
  logic [ADDR_W-1:0]  j_target;
  alu_op_t            alu_op;

  logic [INSTR_W-1:0] rf_rd1;
  logic [INSTR_W-1:0] rf_rd2;
  logic [INSTR_W-1:0] rf_wd;
  logic [4:0]         rf_wa;
  logic               rf_we;

  assign opcode = ir[31:26];
  assign rs     = ir[25:21];
  assign rt     = ir[20:16];
  assign rd     = ir[15:11];
  assign funct  = ir[5:0];
  assign simm   = {{16{ir[15]}}, ir[15:0]};

  assign alu_op   = alu_sel(opcode, funct);
  assign alu_b    = (opcode == OP_RTYPE) ? b_reg : simm;
  assign addr_sum = a_reg + simm;

  always_comb begin
    alu_res = a_reg + alu_b;
    case (alu_op)
      ALU_SUB: alu_res = a_reg - alu_b;
      ALU_AND: alu_res = a_reg & alu_b;
      ALU_OR:  alu_res = a_reg | alu_b;
      ALU_SLT: alu_res = {31'b0, $signed(a_reg) < $signed(alu_b)};
      default: alu_res = a_reg + alu_b;
    endcase
  end

  // Branch/jump targets are formed at full width then truncated, so they wrap modulo 2^ADDR_W.
  assign pc_plus4 = pc + PC_STEP;
  assign br_calc  = pc + ADDR_W'({simm[29:0], 2'b00});
  assign j_full   = (32'(pc) & 32'hF000_0000) | {4'b0000, ir[25:0], 2'b00};
  assign j_target = ADDR_W'(j_full);

  assign rf_we = (state == ST_WB);
  assign rf_wa = (opcode == OP_RTYPE) ? rd : rt;
  assign rf_wd = (opcode == OP_LW) ? mdr : alu_out;

  mips_regfile_revc u_rf (
    .clk   (clk),
    .rst_n (reset),
    .ra1   (rs),
    .ra2   (rt),
    .rd1   (rf_rd1),
    .rd2   (rf_rd2),
    .we    (rf_we),
    .wa    (rf_wa),
    .wd    (rf_wd)
  );

  assign pc_dbg = pc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_FETCH;
      pc        <= RESET_PC;
      br_target <= '0;
      ir        <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      alu_out   <= '0;
      mdr       <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= RESET_PC;
      mem_wdata <= '0;
      halted    <= 1'b0;
      trap      <= 1'b0;
      retire    <= 1'b0;
    end else begin
      retire <= 1'b0;
      case (state)
        // Out of reset req is low; raise it here, every later FETCH entry arrives with it set.
        ST_FETCH: begin
          if (!mem_req) begin
            mem_req <= 1'b1;
          end else if (mem_ack) begin
            ir      <= mem_rdata;
            pc      <= pc_plus4;
            mem_req <= 1'b0;
            state   <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          a_reg     <= rf_rd1;
          b_reg     <= rf_rd2;
          br_target <= br_calc;
          if (opcode == OP_HALT) begin
            halted <= 1'b1;
            state  <= ST_HALT;
          end else if (!is_legal(opcode, funct)) begin
            halted <= 1'b1;
            trap   <= 1'b1;
            state  <= ST_HALT;
          end else begin
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          case (opcode)
            OP_LW, OP_SW: begin
              alu_out <= addr_sum;
              if (addr_sum[1:0] != 2'b00) begin
                halted <= 1'b1;
                trap   <= 1'b1;
                state  <= ST_HALT;
              end else begin
                mem_req  <= 1'b1;
                mem_we   <= (opcode == OP_SW);
                mem_addr <= ADDR_W'(addr_sum);
                if (opcode == OP_SW) mem_wdata <= b_reg;
                state <= ST_MEM;
              end
            end
            OP_BEQ: begin
              if (a_reg == b_reg) begin
                pc       <= br_target;
                mem_addr <= br_target;
              end else begin
                mem_addr <= pc;
              end
              mem_req <= 1'b1;
              retire  <= 1'b1;
              state   <= ST_FETCH;
            end
            OP_J: begin
              pc       <= j_target;
              mem_addr <= j_target;
              mem_req  <= 1'b1;
              retire   <= 1'b1;
              state    <= ST_FETCH;
            end
            default: begin
              alu_out <= alu_res;
              state   <= ST_WB;
            end
          endcase
        end
        ST_MEM: begin
          if (mem_ack) begin
            if (mem_we) begin
              mem_we   <= 1'b0;
              mem_addr <= pc;
              retire   <= 1'b1;
              state    <= ST_FETCH;
            end else begin
              mdr     <= mem_rdata;
              mem_req <= 1'b0;
              state   <= ST_WB;
            end
          end
        end
        ST_WB: begin
          mem_req  <= 1'b1;
          mem_addr <= pc;
          retire   <= 1'b1;
          state    <= ST_FETCH;
        end
        ST_HALT: begin
          state <= ST_HALT;
        end
        default: begin
          state <= ST_HALT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_cpu_revc.sv
// Directed bench for mips_cpu_revc: wide-address instance with RESET_PC=0x200 and a 12-bit instance.
module tb_mips_cpu_revc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        req_a, we_a, ack_a, halted_a, trap_a, retire_a;
  logic [31:0] addr_a, wdata_a, rdata_a, pc_a;
  logic        req_b, we_b, ack_b, halted_b, trap_b, retire_b;
  logic [11:0] addr_b, pc_b;
  logic [31:0] wdata_b, rdata_b;

  logic [31:0] prog_a [1024];
  logic [31:0] mem_a  [1024];
  logic [31:0] prog_b [1024];
  int          wait_a = 0;
  int          cnt_a;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          ret_cnt, ret_b, wr_cnt, stab_err = 0;
  int          ret_cyc[$];
  logic [31:0] acc_addr[$];
  logic [31:0] wr_addr, wr_data;
  logic [11:0] last_b;
  logic        mon_en = 1'b0;
  logic        pend = 1'b0;
  logic        p_we;
  logic [31:0] p_addr, p_wdata;

  always #5 clk = ~clk;

  mips_cpu_revc #(.ADDR_W(32), .RESET_PC(32'h200)) u_a (
    .clk(clk), .reset(rst_n), .mem_req(req_a), .mem_we(we_a), .mem_addr(addr_a),
    .mem_wdata(wdata_a), .mem_rdata(rdata_a), .mem_ack(ack_a), .halted(halted_a),
    .trap(trap_a), .retire(retire_a), .pc_dbg(pc_a)
  );

  mips_cpu_revc #(.ADDR_W(12), .RESET_PC(12'h000)) u_b (
    .clk(clk), .reset(rst_n), .mem_req(req_b), .mem_we(we_b), .mem_addr(addr_b),
    .mem_wdata(wdata_b), .mem_rdata(rdata_b), .mem_ack(ack_b), .halted(halted_b),
    .trap(trap_b), .retire(retire_b), .pc_dbg(pc_b)
  );

  // Memory for instance A: programmable wait states, reloaded from prog_a while in reset.
  assign ack_a   = req_a && (cnt_a == wait_a);
  assign rdata_a = mem_a[addr_a[11:2]];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)              cnt_a <= 0;
    else if (req_a && ack_a) cnt_a <= 0;
    else if (req_a)          cnt_a <= cnt_a + 1;
  end

  always @(posedge clk) begin
    if (!rst_n) mem_a <= prog_a;
    else if (req_a && ack_a && we_a) mem_a[addr_a[11:2]] <= wdata_a;
  end

  // Instance B sees a zero-wait ROM.
  assign ack_b   = req_b;
  assign rdata_b = prog_b[addr_b[11:2]];

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      ret_cnt = 0; ret_b = 0; wr_cnt = 0; pend = 1'b0;
      ret_cyc.delete(); acc_addr.delete();
    end else begin
      if (retire_a) begin ret_cnt++; ret_cyc.push_back(cyc); end
      if (req_a && ack_a) begin
        acc_addr.push_back(addr_a);
        if (we_a) begin wr_cnt++; wr_addr = addr_a; wr_data = wdata_a; end
      end
      if (retire_b) ret_b++;
      if (req_b) last_b = addr_b;
      if (mon_en) begin
        if (pend && !(req_a && addr_a == p_addr && we_a == p_we && wdata_a == p_wdata))
          stab_err++;
        pend = req_a && !ack_a;
        p_addr = addr_a; p_we = we_a; p_wdata = wdata_a;
      end else begin
        pend = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s got=0x%0h exp=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_prog();
    foreach (prog_a[i]) prog_a[i] = 32'h0;
  endtask

  task automatic restart(input int w);
    rst_n = 1'b0;
    wait_a = w;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_to_halt(input string tag, input int max_cyc);
    int n;
    n = 0;
    while (!halted_a && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_halted"}, 32'(halted_a), 32'd1);
  endtask

  initial begin
    int n;
    int n0;
    foreach (prog_b[i]) prog_b[i] = 32'h0;
    prog_b[0]    = 32'h1000FFFE;   // BEQ $0,$0,-2 -> 0x004-8 wraps to 0xFFC
    prog_b[1023] = 32'hFC000000;   // HALT

    // Reset values
    clear_prog();
    prog_a[128] = 32'h20010005;    // ADDI $1,$0,5
    prog_a[129] = 32'h2002FFFD;    // ADDI $2,$0,-3
    prog_a[130] = 32'h00221820;    // ADD  $3,$1,$2
    prog_a[131] = 32'h0041202A;    // SLT  $4,$2,$1
    prog_a[132] = 32'hFC000000;    // HALT
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req",    32'(req_a),   32'd0);
    check("rst_we",     32'(we_a),    32'd0);
    check("rst_addr",   addr_a,       32'h200);
    check("rst_pc",     pc_a,         32'h200);
    check("rst_wdata",  wdata_a,      32'h0);
    check("rst_halted", 32'(halted_a), 32'd0);
    check("rst_trap",   32'(trap_a),  32'd0);
    check("rst_retire", 32'(retire_a), 32'd0);

    // Arithmetic program, zero-wait
    restart(0);
    run_to_halt("t1", 200);
    check("t1_r3",      u_a.u_rf.regs[3], 32'd2);
    check("t1_r4",      u_a.u_rf.regs[4], 32'd1);
    check("t1_retires", 32'(ret_cnt),   32'd4);
    check("t1_trap",    32'(trap_a),    32'd0);
    check("t1_pc",      pc_a,           32'h214);
    check("t1_cpi_addi", 32'(ret_cyc[1] - ret_cyc[0]), 32'd4);
    check("t1_cpi_slt",  32'(ret_cyc[3] - ret_cyc[2]), 32'd4);
    check("b_halted",   32'(halted_b),  32'd1);
    check("b_trap",     32'(trap_b),    32'd0);
    check("b_target",   32'(last_b),    32'hFFC);
    check("b_pc_wrap",  32'(pc_b),      32'h000);
    check("b_retires",  32'(ret_b),     32'd1);

    // Store then load with three wait cycles on every request
    clear_prog();
    prog_a[128] = 32'h20010005;    // ADDI $1,$0,5
    prog_a[129] = 32'hAC010040;    // SW $1,0x40($0)
    prog_a[130] = 32'h8C050040;    // LW $5,0x40($0)
    prog_a[131] = 32'hFC000000;    // HALT
    restart(3);
    mon_en = 1'b1;
    run_to_halt("t2", 400);
    mon_en = 1'b0;
    check("t2_wr_cnt",  32'(wr_cnt),  32'd1);
    check("t2_wr_addr", wr_addr,      32'h40);
    check("t2_wr_data", wr_data,      32'd5);
    check("t2_r5",      u_a.u_rf.regs[5], 32'd5);
    check("t2_stable",  32'(stab_err), 32'd0);
    check("t2_cyc_sw",  32'(ret_cyc[1] - ret_cyc[0]), 32'd10);
    check("t2_cyc_lw",  32'(ret_cyc[2] - ret_cyc[1]), 32'd11);

    // Branches and jump
    clear_prog();
    prog_a[128] = 32'h20010001;    // ADDI $1,$0,1
    prog_a[129] = 32'h10010005;    // BEQ $0,$1,+5 (not taken)
    prog_a[130] = 32'h08000040;    // J 0x100
    prog_a[64]  = 32'h1000FFFE;    // BEQ $0,$0,-2 -> 0xFC
    prog_a[63]  = 32'hFC000000;    // HALT
    restart(0);
    run_to_halt("t3", 200);
    check("t3_fetch1", acc_addr[1], 32'h204);
    check("t3_fetch2", acc_addr[2], 32'h208);
    check("t3_fetch3", acc_addr[3], 32'h100);
    check("t3_fetch4", acc_addr[4], 32'h0FC);
    check("t3_pc",     pc_a,        32'h100);
    check("t3_cpi_beq_nt", 32'(ret_cyc[1] - ret_cyc[0]), 32'd3);
    check("t3_cpi_j",      32'(ret_cyc[2] - ret_cyc[1]), 32'd3);
    check("t3_cpi_beq_t",  32'(ret_cyc[3] - ret_cyc[2]), 32'd3);

    // Illegal opcode
    clear_prog();
    prog_a[128] = 32'hF8000000;    // op 0x3E
    restart(0);
    run_to_halt("t4a", 100);
    check("t4a_trap",    32'(trap_a),  32'd1);
    check("t4a_retires", 32'(ret_cnt), 32'd0);
    repeat (4) @(negedge clk);
    check("t4a_no_req",  32'(req_a),   32'd0);

    // Illegal funct on R-type
    clear_prog();
    prog_a[128] = 32'h20070011;    // ADDI $7,$0,0x11
    prog_a[129] = 32'h00223821;    // R-type funct 0x21 -> $7
    restart(0);
    run_to_halt("t4b", 100);
    check("t4b_trap", 32'(trap_a), 32'd1);
    check("t4b_r7",   u_a.u_rf.regs[7], 32'h11);

    // Misaligned load
    clear_prog();
    prog_a[128] = 32'h20050077;    // ADDI $5,$0,0x77
    prog_a[129] = 32'h8C050042;    // LW $5,0x42($0)
    restart(0);
    run_to_halt("t4c", 100);
    check("t4c_trap", 32'(trap_a), 32'd1);
    check("t4c_r5",   u_a.u_rf.regs[5], 32'h77);
    check("t4c_reqs", 32'(acc_addr.size()), 32'd2);

    // Write to $0 discarded
    clear_prog();
    prog_a[128] = 32'h20000007;    // ADDI $0,$0,7
    prog_a[129] = 32'hFC000000;    // HALT
    restart(0);
    run_to_halt("t5", 100);
    check("t5_r0",      u_a.u_rf.regs[0], 32'h0);
    check("t5_retires", 32'(ret_cnt), 32'd1);

    // Reset pulse while a load waits for ack
    clear_prog();
    prog_a[128] = 32'h8C090040;    // LW $9,0x40($0)
    prog_a[129] = 32'hFC000000;    // HALT
    restart(3);
    n = 0;
    while (!(req_a && addr_a == 32'h40) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t6_lw_req", 32'(req_a && addr_a == 32'h40), 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t6_req",    32'(req_a),    32'd0);
    check("t6_addr",   addr_a,        32'h200);
    check("t6_pc",     pc_a,          32'h200);
    check("t6_retire", 32'(retire_a), 32'd0);
    check("t6_r9",     u_a.u_rf.regs[9], 32'h0);
    #1 rst_n = 1'b1;
    n0 = acc_addr.size();
    n = 0;
    while (acc_addr.size() <= n0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t6_refetch", acc_addr[n0], 32'h200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mips_cpu_revc.md
# mips_cpu_revC

Multicycle, parametrised successor to the single-cycle revB core. It executes the same MIPS subset through a shared instruction/data memory port, using a variable-latency request/acknowledge handshake in place of internal ROM/RAM. It adds a configurable address width and reset vector, an explicit HALT instruction, trap detection, and a retire strobe for bench and debug use. It is the top of the CPU; the memory model or bus bridge sits outside it.

## Interface
- `ADDR_W`, 32: memory byte-address width, legal range 8..32. PC and `mem_addr` are this width.
- `RESET_PC`, 0: PC value after reset. Must be word-aligned.
- `clk` input 1: single clock. All state updates on the rising edge.
- `reset` input 1: asynchronous, active-low reset. Low clears all state immediately.
- `mem_req` output 1: memory request, held until acknowledged.
- `mem_we` output 1: 1 = write (SW), 0 = read (fetch/LW).
- `mem_addr` output ADDR_W: word-aligned byte address.
- `mem_wdata` output 32: store data.
- `mem_rdata` input 32: read data, valid when `mem_ack`=1.
- `mem_ack` input 1: completes the current request.
- `halted` output 1: core stopped, in HALT state.
- `trap` output 1: halt was caused by an illegal opcode/funct or a misaligned LW/SW.
- `retire` output 1: one-cycle pulse per completed instruction.
- `pc_dbg` output ADDR_W: architectural PC.

## Operation
- ISA, with opcode/funct in hex:
  - R-type (op 00): ADD 20, SUB 22, AND 24, OR 25, SLT 2A. SLT is signed. ADD/SUB wrap with no overflow trap.
  - Immediate and memory: ADDI 08 (sign-extended immediate), LW 23, SW 2B.
  - Control: BEQ 04, J 02, HALT 3F.
- FSM states: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH: drive req with `mem_addr`=PC and we=0. On ack: IR<=rdata, PC<=PC+4.
- DECODE: A<=R[rs], B<=R[rt]. Compute branch target = PC + (sext(imm)<<2), modulo 2^ADDR_W. Illegal op/funct -> HALT with trap=1. HALT op -> HALT with trap=0.
- EXEC:
  - R-type/ADDI: ALUOut <= result, go to WB.
  - LW/SW: ALUOut <= A+sext(imm). If bits [1:0]≠0 -> HALT with trap=1, no memory access. Otherwise go to MEM.
  - BEQ: if A==B, PC<=target. Retire, go to FETCH.
  - J: PC <= {PC[31:28], addr26, 2'b00}, with PC zero-extended to 32 bits then truncated to ADDR_W. Retire, go to FETCH.
- MEM: req with `mem_addr`=ALUOut[ADDR_W-1:0].
  - SW: we=1, wdata=B. On ack: retire, go to FETCH.
  - LW: we=0. On ack: MDR<=rdata, go to WB.
- WB: write R[rd] (R-type) or R[rt] (ADDI/LW). Retire, go to FETCH.
- Writes to $0 are discarded; $0 always reads 0.
- HALT is absorbing until reset. It issues no requests and does not retire. HALT instructions and trapping instructions do not assert `retire`.

## Timing
- Reset values:
  - `mem_req`/`mem_we`/`halted`/`trap`/`retire` = 0; `mem_addr`/`pc_dbg` = RESET_PC; `mem_wdata` = 0.
  - All registers R0..R31 = 0; state = FETCH.
  - First request is asserted the first cycle after `reset` deasserts.
- Handshake:
  - req/we/addr/wdata stay stable from req rising until the cycle ack is sampled 1.
  - req drops the cycle after ack unless the next state issues a new request.
  - ack in the same cycle req first rises is legal (zero-wait).
  - ack while req=0 is ignored.
- Cycles per instruction with zero-wait memory: BEQ/J = 3, R-type/ADDI/SW = 4, LW = 5. Each wait cycle on ack adds one.
- `retire` is registered and pulses on the cycle after the last state of the instruction.
- `pc_dbg` updates together with PC.
- Reset asserted mid-request drops req asynchronously. No partial register write may occur.

## Structure
- Package `mips_revc_pkg` holds:
  - opcode and funct constants
  - FSM state enum
  - ALU operation enum (ADD, SUB, AND, OR, SLT)
  - `INSTR_W`=32 and `REG_CNT`=32
- Sub-module `mips_regfile_revc`: 32×32 register file with 2 asynchronous read ports and 1 synchronous write port, $0 hardwired to 0, and the same async active-low reset. The FSM, ALU and PC logic stay in the top.

## Test plan
- Program `ADDI $1,$0,5; ADDI $2,$0,-3; ADD $3,$1,$2; SLT $4,$2,$1; HALT`, zero-wait -> R3=2, R4=1, retire count 4, halted=1, trap=0, pc_dbg=RESET_PC+0x14.
- `SW $1,0x40($0)`, then `LW $5,0x40($0)`, with ack delayed 3 cycles on every request -> write seen with addr 0x40 and wdata 5, R5=5, req/addr stable through all wait cycles, LW takes 5+6 cycles.
- BEQ taken with offset -2 and not-taken, plus `J 0x100` -> PC sequence matches target math, each takes 3 cycles; ADDR_W=12 run wraps the branch target modulo 4096.
- Opcode 0x3E, funct 0x21 on R-type, and `LW` from address 0x42 -> halted=1, trap=1, no memory request for the LW, destination register unchanged.
- `ADDI $0,$0,7` -> R0 stays 0. Reset pulse during a LW wait state -> outputs return to reset values immediately, and the next fetch is at RESET_PC (test with RESET_PC=0x200).
